switching_config_loader: RTL

Serial-to-parallel configuration writer for the switching-generator data unit. It receives a framed bit stream over a valid/ready handshake: seed first, then transform matrix 1, then transform matrix 2. It checks the seed, presents the three words on parallel buses, and then drives a `set` pulse. The data unit captures the buses on the rising edge of that pulse. The loader sits between the host/config port and the data unit's `b_lfsr_set` / `b_trans_1_mat_set` / `b_trans_2_mat_set` / `set` inputs.

---
 rtl/switching_config_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/switching_config_loader.sv
// switching_config_loader
//
// Serial-to-parallel configuration writer for the switching-generator data unit.
// Receives a framed bit stream (seed, matrix 1, matrix 2) over a valid/ready
// handshake, rejects an all-zero seed, presents the three words on parallel
// buses and then raises a two-cycle capture strobe.
//
// Ports:
//   clk               in   system clock
//   rst               in   asynchronous active-high reset
//   load_req          in   start a new frame, or restart one in progress
//   sdata             in   serial configuration bit
//   svalid            in   sdata is valid
//   sready            out  a bit is accepted this cycle when svalid is also high
//   b_lfsr_set        out  [0:M-1]    seed word
//   b_trans_1_mat_set out  [0:M*M-1]  transform matrix 1
//   b_trans_2_mat_set out  [0:M*M-1]  transform matrix 2
//   set               out  capture strobe; rising edge is the capture event
//   busy              out  high in every state except idle
//   err               out  sticky: last frame had an all-zero seed and was rejected

module switching_config_loader #(
  parameter int unsigned M = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_req,
  input  logic           sdata,
  input  logic           svalid,
  output logic           sready,
  output logic [0:M-1]   b_lfsr_set,
  output logic [0:M*M-1] b_trans_1_mat_set,
  output logic [0:M*M-1] b_trans_2_mat_set,
  output logic           set,
  output logic           busy,
  output logic           err
);

  localparam int unsigned MM   = M * M;
  localparam int unsigned N    = M + 2 * MM;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StShift, StCheck, StCommit, StPulse} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [0:N-1]      frame_q, frame_d;
  logic [0:M-1]      seed_q, seed_d;
  logic [0:MM-1]     mat1_q, mat1_d;
  logic [0:MM-1]     mat2_q, mat2_d;
  logic              set_q, set_d;
  logic              err_q, err_d;
  logic              pulse_q, pulse_d;  // second cycle of the strobe
  logic              accept;

  // A restart request masks the handshake so a bit offered alongside it is dropped.
  assign sready = (state_q == StShift) && !load_req;
  assign accept = sready && svalid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    seed_d  = seed_q;
    mat1_d  = mat1_q;
    mat2_d  = mat2_q;
    err_d   = err_q;
    pulse_d = pulse_q;

    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          state_d = StShift;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StShift: begin
        if (load_req) begin
          cnt_d = '0;
        end else if (accept) begin
          frame_d[cnt_q] = sdata;
          // Counter parks at N-1 on the final bit rather than wrapping.
          if (cnt_q == CntW'(N - 1)) begin
            state_d = StCheck;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCheck: begin
        if (frame_q[0 +: M] == '0) begin
          // An all-zero seed would lock the generator: keep the old buses.
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          state_d = StCommit;
          seed_d  = frame_q[0 +: M];
          mat1_d  = frame_q[M +: MM];
          mat2_d  = frame_q[M + MM +: MM];
        end
      end
      StCommit: begin
        state_d = StPulse;
        pulse_d = 1'b0;
      end
      StPulse: begin
        if (pulse_q) begin
          state_d = StIdle;
          pulse_d = 1'b0;
        end else begin
          pulse_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    set_d = (state_d == StPulse);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= '0;
      seed_q  <= '0;
      mat1_q  <= '0;
      mat2_q  <= '0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      seed_q  <= seed_d;
      mat1_q  <= mat1_d;
      mat2_q  <= mat2_d;
      set_q   <= set_d;
      err_q   <= err_d;
      pulse_q <= pulse_d;
    end
  end

  assign b_lfsr_set        = seed_q;
  assign b_trans_1_mat_set = mat1_q;
  assign b_trans_2_mat_set = mat2_q;
  assign set               = set_q;
  assign busy              = (state_q != StIdle);
  assign err               = err_q;

endmodule
